block_scheduler: RTL

Parametrised kernel block scheduler: successor to the fixed top-level dispatch unit. Splits a launched kernel's thread count into fixed-size blocks and issues them one per cycle to free compute cores in round-robin order. Counts completions, supports abort and overflow detection, and holds idle cores in reset. It sits at GPU top level between the device control register and the core array.

---
 rtl/block_scheduler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/block_scheduler.sv
// Kernel block scheduler: splits a launched kernel into fixed-size blocks and
// issues them round-robin to free cores, tracking completions, abort and overflow.
module block_scheduler #(
    parameter int unsigned NUM_CORES          = 4,
    parameter int unsigned THREADS_PER_BLOCK  = 4,
    parameter int unsigned THREAD_COUNT_WIDTH = 16,
    parameter int unsigned BLOCK_ID_WIDTH     = 12
) (
    input  logic                                                         clk,
    input  logic                                                         reset_n,
    input  logic                                                         start,
    input  logic                                                         abort,
    input  logic [THREAD_COUNT_WIDTH-1:0]                                thread_count,
    input  logic [NUM_CORES-1:0]                                         core_done,
    output logic [NUM_CORES-1:0]                                         core_start,
    output logic [NUM_CORES-1:0]                                         core_reset,
    output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0]                          core_block_id,
    output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0]           core_thread_count,
    output logic                                                         busy,
    output logic                                                         done,
    output logic                                                         aborted,
    output logic                                                         error,
    output logic [BLOCK_ID_WIDTH:0]                                      blocks_done_count
);

    localparam int unsigned LOG_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int unsigned CTW     = LOG_TPB + 1;
    localparam int unsigned TBW     = THREAD_COUNT_WIDTH + 1;
    localparam int unsigned CNTW    = BLOCK_ID_WIDTH + 1;
    localparam int unsigned CMPW    = (TBW > CNTW + 1) ? TBW : CNTW + 1;
    localparam int unsigned PTRW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned MULW    = TBW + LOG_TPB;
    localparam logic [CMPW-1:0] MAX_BLOCKS = CMPW'(1) << BLOCK_ID_WIDTH;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                              state_q, state_d;
    logic [THREAD_COUNT_WIDTH-1:0]       tc_q, tc_d;
    logic [TBW-1:0]                      total_q, total_d;
    logic [TBW-1:0]                      next_q, next_d;
    logic [PTRW-1:0]                     ptr_q, ptr_d;
    logic [NUM_CORES-1:0]                start_d, reset_d;
    logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] id_d;
    logic [NUM_CORES*CTW-1:0]            thr_d;
    logic                                busy_d, done_d, aborted_d, error_d;
    logic [CNTW-1:0]                     count_d;

    logic [TBW-1:0]                      total_blocks_c;
    logic [NUM_CORES-1:0]                finish_c;
    logic [CNTW-1:0]                     n_fin_c;
    logic [CNTW-1:0]                     count_upd_c;
    logic                                sel_ok_c;
    logic [PTRW-1:0]                     sel_c;
    logic [MULW-1:0]                     rem_c;
    logic [CTW-1:0]                      blk_thr_c;

    // Free-core search, block sizing and completion popcount
    always_comb begin
        total_blocks_c = TBW'((TBW'(thread_count) + TBW'(THREADS_PER_BLOCK - 1)) >> LOG_TPB);
        finish_c       = core_start & core_done;
        n_fin_c        = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            n_fin_c = n_fin_c + CNTW'(finish_c[c]);
        end
        count_upd_c = blocks_done_count + n_fin_c;

        sel_ok_c = 1'b0;
        sel_c    = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (!sel_ok_c && core_reset[c] && (PTRW'(c) >= ptr_q)) begin
                sel_ok_c = 1'b1;
                sel_c    = PTRW'(c);
            end
        end
        for (int c = 0; c < NUM_CORES; c++) begin
            if (!sel_ok_c && core_reset[c] && (PTRW'(c) < ptr_q)) begin
                sel_ok_c = 1'b1;
                sel_c    = PTRW'(c);
            end
        end

        rem_c     = MULW'(tc_q) - (MULW'(next_q) << LOG_TPB);
        blk_thr_c = (next_q == total_q - TBW'(1)) ? CTW'(rem_c) : CTW'(THREADS_PER_BLOCK);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        tc_d      = tc_q;
        total_d   = total_q;
        next_d    = next_q;
        ptr_d     = ptr_q;
        start_d   = core_start;
        reset_d   = core_reset;
        id_d      = core_block_id;
        thr_d     = core_thread_count;
        busy_d    = busy;
        done_d    = done;
        aborted_d = aborted;
        error_d   = error;
        count_d   = blocks_done_count;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tc_d      = thread_count;
                    total_d   = total_blocks_c;
                    next_d    = '0;
                    ptr_d     = '0;
                    count_d   = '0;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    error_d   = 1'b0;
                    if (total_blocks_c == '0) begin
                        state_d = DONE;
                    end else if (CMPW'(total_blocks_c) > MAX_BLOCKS) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = DISPATCH;
                    end
                end
            end
            DISPATCH, DRAIN: begin
                start_d = core_start & ~finish_c;
                reset_d = core_reset | finish_c;
                count_d = count_upd_c;
                // Only cores already in reset are eligible, so issue never collides with completion
                if (state_q == DISPATCH && sel_ok_c) begin
                    for (int c = 0; c < NUM_CORES; c++) begin
                        if (PTRW'(c) == sel_c) begin
                            reset_d[c] = 1'b0;
                            start_d[c] = 1'b1;
                            id_d[c*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH] = BLOCK_ID_WIDTH'(next_q);
                            thr_d[c*CTW +: CTW] = blk_thr_c;
                        end
                    end
                    next_d = next_q + TBW'(1);
                    ptr_d  = (sel_c == PTRW'(NUM_CORES - 1)) ? '0 : sel_c + PTRW'(1);
                    if (next_q + TBW'(1) == total_q) begin
                        state_d = DRAIN;
                    end
                end
                if (abort) begin
                    start_d   = '0;
                    reset_d   = '1;
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end else if (CMPW'(count_upd_c) == CMPW'(total_q)) begin
                    start_d = '0;
                    reset_d = '1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                start_d = '0;
                reset_d = '1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!start) begin
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    error_d   = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            tc_q              <= '0;
            total_q           <= '0;
            next_q            <= '0;
            ptr_q             <= '0;
            core_start        <= '0;
            core_reset        <= '1;
            core_block_id     <= '0;
            core_thread_count <= {NUM_CORES{CTW'(THREADS_PER_BLOCK)}};
            busy              <= 1'b0;
            done              <= 1'b0;
            aborted           <= 1'b0;
            error             <= 1'b0;
            blocks_done_count <= '0;
        end else begin
            state_q           <= state_d;
            tc_q              <= tc_d;
            total_q           <= total_d;
            next_q            <= next_d;
            ptr_q             <= ptr_d;
            core_start        <= start_d;
            core_reset        <= reset_d;
            core_block_id     <= id_d;
            core_thread_count <= thr_d;
            busy              <= busy_d;
            done              <= done_d;
            aborted           <= aborted_d;
            error             <= error_d;
            blocks_done_count <= count_d;
        end
    end

endmodule
